// File: rtl/sar_result_averager_if.sv
// sar_result_averager_if: valid/ready port carrying averaged SAR codes to the readout logic.
interface sar_result_averager_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  modport master (output out_valid, out_data, input out_ready);
  modport slave  (input out_valid, out_data, output out_ready);
endinterface

// File: rtl/sar_result_averager.sv
// sar_result_averager: re-arms an 8-bit SAR after every conversion, averages 2**AVG_LOG2 codes
// and queues each average in a small FIFO read through a valid/ready port.
module sar_result_averager #(
  parameter int AVG_LOG2       = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int RESTART_CYCLES = 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  conv_done,
  input  logic [7:0]            conv_code,
  output logic                  sar_rst_n_o,
  sar_result_averager_if.master res,
  output logic [LW-1:0]         fifo_level,
  output logic                  ovf,
  input  logic                  ovf_clr
);
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int RW = RESTART_CYCLES > 1 ? $clog2(RESTART_CYCLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {RESTART, WAIT} state_t;
  state_t        state;
  logic [RW-1:0] rcnt;
  logic          sar_q;
  logic          done_q;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          capture;
  logic          last;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [7:0]    avg;
  assign capture     = en & conv_done & ~done_q & (state == WAIT);
  assign last        = cnt == CW'((1 << AVG_LOG2) - 1);
  assign sum         = acc + AW'(conv_code);
  assign avg         = 8'(sum >> AVG_LOG2);
  assign push        = capture & last;
  assign full        = fifo_level == LW'(FIFO_DEPTH);
  assign pop         = res.out_valid & res.out_ready;
  assign push_ok     = push & (~full | pop);
  assign res.out_valid = fifo_level != '0;
  assign res.out_data  = mem[rp];
  assign sar_rst_n_o = sar_q & rst_n;
  // disabling or capturing both restart the re-arm pulse from its full length
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RESTART;
      rcnt  <= RW'(RESTART_CYCLES - 1);
      sar_q <= 1'b0;
    end else if (!en || capture) begin
      state <= RESTART;
      rcnt  <= RW'(RESTART_CYCLES - 1);
      sar_q <= 1'b0;
    end else if (state == RESTART) begin
      if (rcnt == '0) begin
        state <= WAIT;
        sar_q <= 1'b1;
      end else
        rcnt <= rcnt - RW'(1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      done_q <= 1'b0;
    else
      done_q <= conv_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (!en) begin
      acc <= '0;
      cnt <= '0;
    end else if (capture) begin
      acc <= last ? '0 : sum;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  // a push into a full FIFO still lands when the head leaves in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wp] <= avg;
        wp      <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);
      ovf        <= (push & full & ~pop) | (ovf & ~ovf_clr);
    end
endmodule
